// File: rtl/uart_tx_sink_pkg.sv
// Shared definitions for the console UART transmitter: frame geometry and FSM states.
package uart_tx_sink_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FRAME_BITS = UART_DATA_BITS + 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_sink_sync_fifo.sv
// Plain synchronous FIFO with occupancy count; the caller decides what to do when full.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

    // NOTE: storage is deliberately not reset; the pointers and level decide what is valid,
    // and a reset-free array maps onto RAM instead of a wall of flops.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (level == LVL_W'(DEPTH));
    assign empty = (level == '0);

endmodule

// File: rtl/uart_tx_sink.sv
// Console sink: queues bytes written by the CPU and serialises them as 8N1 UART on tx.
module uart_tx_sink
    import uart_tx_sink_pkg::*;
#(
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 16,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      in_byte,
    input  logic             in_byte_en,
    output logic             tx,
    output logic             busy,
    output logic             full,
    output logic             overflow,
    output logic [LVL_W-1:0] level
);

    localparam int                CNT_W    = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [2:0]        BIT_LAST = 3'(UART_DATA_BITS - 1);

    tx_state_e                 state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [2:0]                idx_q, idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      tx_d;
    logic                      push, pop, bit_end;
    logic                      fifo_empty;
    logic [UART_DATA_BITS-1:0] fifo_dout;
    logic                      unused_upper;

    assign unused_upper = ^in_byte[31:8];

    // Full is the pre-edge value, so a same-edge pop never rescues a write to a full FIFO.
    assign push = in_byte_en && !full;

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (in_byte[UART_DATA_BITS-1:0]),
        .dout  (fifo_dout),
        .full  (full),
        .empty (fifo_empty),
        .level (level)
    );

    assign bit_end = (cnt_q == CNT_LAST);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        pop     = 1'b0;

        if (state_q != ST_IDLE) cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == BIT_LAST) state_d = ST_STOP;
                    else                   idx_d   = idx_q + 3'd1;
                end
            end
            ST_STOP: begin
                // Chain straight into the next start bit when more data is waiting.
                if (bit_end) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_dout;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            tx       <= 1'b1;
            overflow <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            tx       <= tx_d;
            if (in_byte_en && full) overflow <= 1'b1;
        end
    end

    assign busy = (state_q != ST_IDLE) || (level != '0);

endmodule

// File: tb/tb_uart_tx_sink.sv
// Scoreboard bench for uart_tx_sink: a frame-level timing model predicts every frame and flag.
module tb_uart_tx_sink;

    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int LVL_W      = 3;
    localparam int FRAME      = 10 * CLK_DIV;
    localparam int NEVER      = 32'h7fff_ffff;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [31:0]      in_byte = '0;
    logic             in_byte_en = 1'b0;
    logic             tx, busy, full, overflow;
    logic [LVL_W-1:0] level;

    uart_tx_sink #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH),
        .LVL_W      (LVL_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_byte    (in_byte),
        .in_byte_en (in_byte_en),
        .tx         (tx),
        .busy       (busy),
        .full       (full),
        .overflow   (overflow),
        .level      (level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // One accepted byte: edge it was written, edge its frame begins, payload.
    typedef struct {
        int         push_e;
        int         start_e;
        logic [7:0] data;
    } frame_t;

    frame_t acc[$];
    int     last_start = -1000;
    int     ovf_edge   = NEVER;
    int     epoch      = 0;
    bit     run_chk    = 1'b0;
    int     mon_idx    = 0;
    bit     in_frame   = 1'b0;
    int     tests      = 0;
    int     fails      = 0;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Occupancy after edge c: written at or before c, not yet popped by a frame start.
    function automatic int model_level(input int c);
        int n = 0;
        foreach (acc[i]) if (acc[i].push_e <= c && acc[i].start_e > c) n++;
        return n;
    endfunction

    function automatic bit model_busy(input int c);
        if (model_level(c) != 0) return 1'b1;
        foreach (acc[i]) if (c >= acc[i].start_e && c < acc[i].start_e + FRAME) return 1'b1;
        return 1'b0;
    endfunction

    // A write at edge e sees the occupancy from before that edge; frames run back to back.
    task automatic model_push(input int e, input logic [31:0] d);
        int     n = 0;
        frame_t f;
        foreach (acc[i]) if (acc[i].push_e < e && acc[i].start_e >= e) n++;
        if (n >= FIFO_DEPTH) begin
            if (e < ovf_edge) ovf_edge = e;
        end else begin
            f.push_e  = e;
            f.start_e = (e + 1 > last_start + FRAME) ? e + 1 : last_start + FRAME;
            f.data    = d[7:0];
            acc.push_back(f);
            last_start = f.start_e;
        end
    endtask

    task automatic model_reset();
        acc.delete();
        last_start = -1000;
        ovf_edge   = NEVER;
        epoch++;
    endtask

    task automatic drive(input bit en, input logic [31:0] d);
        @(negedge clk);
        reset      = 1'b0;
        in_byte_en = en;
        in_byte    = d;
        if (en) model_push(cyc + 1, d);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, $urandom);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        in_byte_en = 1'b0;
        model_reset();
    endtask

    // Flag checker: occupancy, full, overflow and busy against the model after every edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (run_chk) begin
                check(level == LVL_W'(model_level(cyc)), "level", int'(level), model_level(cyc));
                check(full === (model_level(cyc) == FIFO_DEPTH), "full", int'(full),
                      int'(model_level(cyc) == FIFO_DEPTH));
                check(overflow === (ovf_edge <= cyc), "overflow", int'(overflow), int'(ovf_edge <= cyc));
                check(busy === model_busy(cyc), "busy", int'(busy), int'(model_busy(cyc)));
            end
        end
    end

    // Line monitor: decodes tx and pops the next expected frame when a start bit appears.
    initial begin
        int         my_epoch = 0;
        int         s = 0;
        int         errs = 0;
        int         off, k;
        logic       exp_bit;
        logic [7:0] dec = '0;
        frame_t     e;
        forever begin
            @(posedge clk);
            #1;
            if (!run_chk) continue;
            if (epoch != my_epoch) begin
                my_epoch = epoch;
                mon_idx  = 0;
                in_frame = 1'b0;
            end
            if (!in_frame) begin
                if (tx === 1'b0) begin
                    check(mon_idx < acc.size(), "frame_expected", mon_idx, acc.size());
                    if (mon_idx < acc.size()) begin
                        e = acc[mon_idx];
                        mon_idx++;
                        s        = cyc;
                        errs     = 0;
                        in_frame = 1'b1;
                        check(s == e.start_e, "frame_start", s, e.start_e);
                    end
                end else begin
                    check(tx === 1'b1, "tx_idle", int'(tx), 1);
                end
            end
            if (in_frame) begin
                off = cyc - s;
                k   = off / CLK_DIV;
                if (k == 0)      exp_bit = 1'b0;
                else if (k == 9) exp_bit = 1'b1;
                else             exp_bit = e.data[k-1];
                if (tx !== exp_bit) errs++;
                if (k >= 1 && k <= 8 && off % CLK_DIV == CLK_DIV / 2) dec[k-1] = tx;
                if (off == FRAME - 1) begin
                    check(errs == 0, "frame_bits", errs, 0);
                    check(dec == e.data, "frame_byte", int'(dec), int'(e.data));
                    in_frame = 1'b0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        drive(1'b0, '0);
        run_chk = 1'b1;
        idle(3);

        // Single byte, then upper input bits must be ignored.
        drive(1'b1, 32'h0000_0041);
        idle(FRAME + 5);
        drive(1'b1, 32'hFFFF_FF42);
        idle(FRAME + 5);

        // Back-to-back "Hi": the second start bit follows the first stop bit directly.
        drive(1'b1, 32'h48);
        drive(1'b1, 32'h69);
        idle(2 * FRAME + 5);

        // Six writes on consecutive edges into a four-entry FIFO: the sixth is dropped.
        for (int i = 0; i < 6; i++) drive(1'b1, 32'h30 + i);
        idle(5 * FRAME + 5);

        // Reset clears the sticky overflow.
        do_reset();
        idle(3);

        // Reset during the data bits of the first frame with two bytes still queued.
        drive(1'b1, 32'h61);
        drive(1'b1, 32'h62);
        drive(1'b1, 32'h63);
        idle(3 * CLK_DIV);
        do_reset();
        @(posedge clk);
        #1;
        check(tx === 1'b1, "tx_after_reset", int'(tx), 1);
        idle(2 * FRAME);

        // Random traffic, with one reset in the middle.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            else          drive($urandom_range(0, 99) < 35, $urandom);
        end
        idle((FIFO_DEPTH + 1) * FRAME + 10);

        check(mon_idx == acc.size(), "frames_emitted", mon_idx, acc.size());
        check(in_frame == 1'b0, "frame_complete", int'(in_frame), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
